// File: rtl/load_hazard_stall_unit.sv
// Load-use hazard detector for a memory with MEM_LAT extra read cycles; tracks in-flight loads until forwardable.
// Optional saturating stall counter enabled by the HAZARD_STATS_EN macro.
module load_hazard_stall_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_valid,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_rt_used,
    output logic              pc_write,
    output logic              if_write,
    output logic              reset_id_control,
    output logic [CNT_W-1:0]  stall_cycles
);

    function automatic logic src_match(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              rt_used
    );
        return (r != '0) && ((r == rs) || (rt_used && (r == rt)));
    endfunction

    logic ex_load;
    logic ex_hit;
    logic pend_hit;
    logic hazard;

    assign ex_load = id_ex_valid & id_ex_mem_read;
    assign ex_hit  = ex_load & src_match(id_ex_rt, if_id_rs, if_id_rt, if_id_rt_used);

    generate
        if (MEM_LAT > 0) begin : g_tracker
            logic [MEM_LAT-1:0] pend_valid;
            logic [REG_AW-1:0]  pend_dest [MEM_LAT];

            // Shift register of in-flight loads; shifts every cycle, stall or not.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_valid <= '0;
                    for (int k = 0; k < int'(MEM_LAT); k++) pend_dest[k] <= '0;
                end else begin
                    pend_valid[0] <= ex_load & (id_ex_rt != '0);
                    pend_dest[0]  <= id_ex_rt;
                    for (int k = 1; k < int'(MEM_LAT); k++) begin
                        pend_valid[k] <= pend_valid[k-1];
                        pend_dest[k]  <= pend_dest[k-1];
                    end
                end
            end

            always_comb begin
                pend_hit = 1'b0;
                for (int k = 0; k < int'(MEM_LAT); k++) begin
                    if (pend_valid[k] && src_match(pend_dest[k], if_id_rs, if_id_rt, if_id_rt_used))
                        pend_hit = 1'b1;
                end
            end
        end else begin : g_no_tracker
            assign pend_hit = 1'b0;
        end
    endgenerate

    assign hazard           = ex_hit | pend_hit;
    assign pc_write         = ~hazard;
    assign if_write         = ~hazard;
    assign reset_id_control = hazard;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (hazard && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = '0;
`endif

    // Keeps clock/reset referenced in the flop-free configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

endmodule

// File: tb/tb_load_hazard_stall_unit.sv
// Directed bench for load_hazard_stall_unit at MEM_LAT=0..3 on shared stimulus, checked against a load-history model.
// Counter expectations follow the HAZARD_STATS_EN macro.
module tb_load_hazard_stall_unit;

`ifdef HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       id_ex_valid;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_rt_used;

    logic [3:0]  pcw;
    logic [3:0]  ifw;
    logic [3:0]  rid;
    logic [15:0] cnt_a [3];
    logic [3:0]  cnt3;

    int checks = 0;
    int errors = 0;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            load_hazard_stall_unit #(.REG_AW(5), .MEM_LAT(g), .CNT_W(16)) dut (
                .clk(clk), .rst_n(rst_n),
                .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
                .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rt_used(if_id_rt_used),
                .pc_write(pcw[g]), .if_write(ifw[g]), .reset_id_control(rid[g]),
                .stall_cycles(cnt_a[g])
            );
        end
    endgenerate

    load_hazard_stall_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rt_used(if_id_rt_used),
        .pc_write(pcw[3]), .if_write(ifw[3]), .reset_id_control(rid[3]),
        .stall_cycles(cnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [3:0]  hz;
        int unsigned cnt [4];
    } exp_t;

    exp_t        sb [$];
    logic [4:0]  hist [3];
    int unsigned mcnt [4];

    function automatic bit reg_match(input logic [4:0] r);
        return (r != 5'd0) && ((r == if_id_rs) || (if_id_rt_used && (r == if_id_rt)));
    endfunction

    // Hazard for a MEM_LAT=lat design: load in EX, or any of the last lat loads.
    function automatic bit model_hazard(input int lat);
        bit h;
        h = id_ex_valid && id_ex_mem_read && reg_match(id_ex_rt);
        for (int k = 0; k < lat; k++) if (reg_match(hist[k])) h = 1'b1;
        return h;
    endfunction

    function automatic int unsigned dut_cnt(input int lat);
        if (lat == 3) return int'(cnt3);
        return int'(cnt_a[lat]);
    endfunction

    task automatic chk(input string name, input int lat, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat=%0d observed=%0d expected=%0d", name, lat, obs, exp);
        end
    endtask

    // One cycle: settle, predict, compare combinational outputs and counters, then clock the model.
    task automatic step(input string tag);
        exp_t e;
        exp_t o;
        #1;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hist[k] = 5'd0;
            for (int l = 0; l < 4; l++) mcnt[l] = 0;
        end
        e.tag = tag;
        for (int l = 0; l < 4; l++) begin
            e.hz[l]  = model_hazard(l);
            e.cnt[l] = STATS_EN ? mcnt[l] : 0;
        end
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        for (int l = 0; l < 4; l++) begin
            chk({o.tag, ".pc_write"}, l, int'(pcw[l]), int'(!o.hz[l]));
            chk({o.tag, ".if_write"}, l, int'(ifw[l]), int'(!o.hz[l]));
            chk({o.tag, ".reset_id_control"}, l, int'(rid[l]), int'(o.hz[l]));
            chk({o.tag, ".stall_cycles"}, l, dut_cnt(l), o.cnt[l]);
        end
        @(posedge clk);
        if (rst_n) begin
            for (int l = 0; l < 4; l++) begin
                if (e.hz[l] && mcnt[l] < ((l == 3) ? 32'd15 : 32'd65535)) mcnt[l]++;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (id_ex_valid && id_ex_mem_read) ? id_ex_rt : 5'd0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic used);
        id_ex_valid    = v;
        id_ex_mem_read = mr;
        id_ex_rt       = ert;
        if_id_rs       = rs;
        if_id_rt       = rt;
        if_id_rt_used  = used;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) hist[k] = 5'd0;
        for (int l = 0; l < 4; l++) mcnt[l] = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        step("reset_zero");
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        step("reset_ex_match");
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("idle");

        // Classic load-use on rs
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        step("rs_load");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
            step("rs_bubble");
        end

        // Dependency through rt
        drive(1'b1, 1'b1, 5'd8, 5'd0, 5'd8, 1'b1);
        step("rt_load");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1);
            step("rt_bubble");
        end

        // Register 0 and unread rt never stall
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        step("r0_load");
        drive(1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0);
        step("rt_unused");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1);
            step("r0_drain");
        end

        // Non-load and squashed load in EX
        drive(1'b1, 1'b0, 5'd4, 5'd4, 5'd0, 1'b0);
        step("alu_in_ex");
        drive(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        step("squashed_load");

        // Back-to-back loads, consumer reads both
        drive(1'b1, 1'b1, 5'd5, 5'd1, 5'd2, 1'b1);
        step("two_load_a");
        drive(1'b1, 1'b1, 5'd6, 5'd1, 5'd2, 1'b1);
        step("two_load_b");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd5, 5'd6, 1'b1);
            step("two_consumer");
        end

        // Asynchronous reset during a stall
        drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
        step("rst_load");
        drive(1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
        step("rst_stall");
        #2;
        rst_n = 1'b0;
        step("rst_mid");
        rst_n = 1'b1;
        step("rst_release");
        step("rst_after");

        // Continuous hazard to saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
            step("saturate");
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("drain_0");
        step("drain_1");
        step("drain_2");
        step("drain_3");
        chk("saturated_count", 3, int'(cnt3), STATS_EN ? 15 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_hazard_stall_unit.md
# load_hazard_stall_unit

Parametrised load-use hazard detector for the 5-stage pipeline. It generalises the single-bubble load-use stall to a data memory with a configurable extra read latency, tracking every in-flight load until its data becomes forwardable. It sits in the ID stage and drives the PC write enable, the IF/ID write enable and the ID/EX control-zeroing (bubble) signal. Register 0 never causes a hazard. An optional stall-cycle counter is available.

## Interface
Parameters:
- REG_AW, default 5: register-address width.
- MEM_LAT, default 0: extra cycles after MEM before load data is forwardable. 0 gives the classic one-bubble load-use stall.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_ex_valid  in  1  ID/EX holds a real (non-squashed, non-bubble) instruction.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_AW  destination register of the load in EX.
- if_id_rs  in  REG_AW  source register rs of the instruction in ID.
- if_id_rt  in  REG_AW  source register rt of the instruction in ID.
- if_id_rt_used  in  1  instruction in ID reads rt (R-type, branch, store).
- pc_write  out  1  PC update enable.
- if_write  out  1  IF/ID register write enable.
- reset_id_control  out  1  zero the control bits entering ID/EX (insert a bubble).
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

## Operation
- Pending-load tracker: a shift register of MEM_LAT entries, pend[1..MEM_LAT]. Each entry holds {valid, dest[REG_AW-1:0]}. When MEM_LAT=0, no tracker exists.
- Each clock edge:
  - pend[1] <= {id_ex_valid & id_ex_mem_read & (id_ex_rt != 0), id_ex_rt}.
  - pend[k] <= pend[k-1] for k = 2..MEM_LAT.
  - The last entry drops out, because its data is now forwardable.
- A source matches a register r when both hold:
  - r != 0, and
  - r == if_id_rs, or (if_id_rt_used and r == if_id_rt).
- hazard is asserted when either:
  - id_ex_valid & id_ex_mem_read and id_ex_rt matches, or
  - any valid pend[k].dest matches.
- Outputs are combinational from the inputs and the registered state:
  - pc_write = !hazard
  - if_write = !hazard
  - reset_id_control = hazard
- The tracker shifts every cycle regardless of hazard. A bubble inserted into ID/EX arrives with id_ex_valid=0, so it enters pend[1] as invalid.
- A dependent instruction held in ID stalls for exactly MEM_LAT+1 cycles after its producing load enters EX, then is released.
- Back-to-back loads to different registers are tracked independently. The stall lasts until the youngest matching load drains.
- A load whose destination is register 0 is never tracked and never stalls.

## Timing
- Combinational path from inputs to pc_write, if_write and reset_id_control: no registered latency.
- Tracker latency: a load occupies EX in cycle n and pend[k] in cycle n+k.
- Reset (rst_n low, asynchronous):
  - all pend valid bits cleared;
  - stall_cycles = 0.
- Outputs while in reset:
  - stall outputs depend only on the id_ex_* and if_id_* inputs;
  - all-zero inputs give pc_write=1, if_write=1, reset_id_control=0.
- Reset deasserted mid-stall: the tracker restarts empty. A stall remains only if the load in EX currently matches.
- stall_cycles increments on every rising edge where hazard=1 and saturates at 2^CNT_W-1. It never wraps.
- Simultaneous cases:
  - a match in EX and a match in pend give a single stall, no double counting;
  - rs and rt matching different loads stall until both drain.

## Configuration
- HAZARD_STATS_EN:
  - Defined: the stall_cycles counter is implemented as described.
  - Undefined: no counter flops; stall_cycles is tied to 0.
- Stall behaviour is identical with and without the macro.

## Test plan
- Classic case, MEM_LAT=0:
  - Stimulus: load r8 in EX (valid, mem_read); ID has rs=8.
  - Required: pc_write=0, if_write=0, reset_id_control=1 for 1 cycle; bubble next cycle gives a release; stall_cycles=1.
- MEM_LAT=2:
  - Stimulus: load r8 enters EX at cycle 0; ID has rt=8 with if_id_rt_used=1.
  - Required: stall in cycles 0, 1 and 2; release in cycle 3; stall_cycles=3.
- Register 0 and rt not read:
  - Stimulus: load r0 with ID rs=0, then load r9 with ID rt=9 and if_id_rt_used=0.
  - Required: no stall in either case.
- Two loads, MEM_LAT=1:
  - Stimulus: load r5 then load r6 back to back; then ID has rs=5, rt=6.
  - Required: stall until r6 leaves pend[1]; exactly 2 stall cycles after the consumer reaches ID.
- Mid-stall reset:
  - Stimulus: MEM_LAT=3; assert rst_n=0 asynchronously during a stall; release with id_ex_valid=0.
  - Required: pend cleared, stall_cycles=0, pc_write=1 immediately.
- Saturation and macro:
  - Stimulus: CNT_W=4 with continuous hazard for 20 cycles.
  - Required: stall_cycles=15 with HAZARD_STATS_EN defined; 0 without it.
